// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// The negate helper works on a fixed wide vector; callers zero-extend and slice.
package muldiv_pkg;

  localparam int unsigned MAX_W = 128;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Two's-complement negate when neg is set; modular, so the low bits of the
  // result are correct for any narrower operand that was zero-extended.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes up front; signs are restored in FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32  // even, 4..64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned   CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e state, state_nxt;

  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               zero_div;

  logic             op_div;
  logic             op_signed;
  logic             sign_a;
  logic             sign_b;
  logic             b_zero;
  logic [MAX_W-1:0] abs_a;
  logic [MAX_W-1:0] abs_b;
  logic [MAX_W-1:0] prod_fix;
  logic [MAX_W-1:0] quot_fix;
  logic [MAX_W-1:0] rem_fix;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] hi_fix;
  logic [WIDTH-1:0] lo_fix;
  logic             unused_wide;

  assign busy = (state != IDLE);

  always_comb begin
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    sign_a    = op_signed & a[WIDTH-1];
    sign_b    = op_signed & b[WIDTH-1];
    b_zero    = (b == '0);
    abs_a     = cond_neg(MAX_W'(a), sign_a);
    abs_b     = cond_neg(MAX_W'(b), sign_b);
  end

  // acc holds the product for multiply, {remainder, quotient} for divide.
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, operand};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {acc[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = {add_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = cond_neg(MAX_W'(acc), neg_q);
    quot_fix = cond_neg(MAX_W'(acc[WIDTH-1:0]), neg_q);
    rem_fix  = cond_neg(MAX_W'(acc[2*WIDTH-1:WIDTH]), neg_r);
    if (is_div) begin
      hi_fix = rem_fix[WIDTH-1:0];
      lo_fix = quot_fix[WIDTH-1:0];
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
    unused_wide = ^{abs_a, abs_b, prod_fix, quot_fix, rem_fix};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (op_div && b_zero) ? FIX : CALC;
        end
      end
      CALC: begin
        if (count == LAST_STEP) begin
          state_nxt = FIX;
        end
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      operand  <= '0;
      acc      <= '0;
      count    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div   <= op_div;
            zero_div <= op_div && b_zero;
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            operand  <= op_div ? abs_b[WIDTH-1:0] : abs_a[WIDTH-1:0];
            acc      <= {{WIDTH{1'b0}}, (op_div ? abs_a[WIDTH-1:0] : abs_b[WIDTH-1:0])};
            count    <= '0;
          end
        end
        CALC: begin
          acc   <= acc_step;
          count <= count + 1'b1;
        end
        FIX: begin
          done     <= 1'b1;
          div_zero <= zero_div;
          if (!zero_div) begin
            hi <= hi_fix;
            lo <= lo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
